// File: rtl/dm_write_arbiter_if.sv
// rtl/dm_write_arbiter_if.sv - core, host and status bundle for the shared data memory
interface dm_write_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
);
    logic [N_CORES*16-1:0]     core_addr;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]        core_wen;
    logic [N_CORES*DATA_W-1:0] core_rdata;
    logic                      host_wen;
    logic [ADDR_W-1:0]         host_addr;
    logic [DATA_W-1:0]         host_wdata;
    logic [N_CORES-1:0]        wbuf_full;
    logic [N_CORES-1:0]        overflow;
    logic                      idle;

    modport master (
        output core_addr, core_wdata, core_wen,
        output host_wen, host_addr, host_wdata,
        input  core_rdata, wbuf_full, overflow, idle
    );

    modport slave (
        input  core_addr, core_wdata, core_wen,
        input  host_wen, host_addr, host_wdata,
        output core_rdata, wbuf_full, overflow, idle
    );
endinterface

// File: rtl/dm_write_arbiter.sv
// rtl/dm_write_arbiter.sv - shared data memory with per-core write FIFOs and round-robin drain
module dm_write_arbiter #(
    parameter int N_CORES    = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int WBUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    dm_write_arbiter_if.slave  bus
);
    localparam int PTR_W     = $clog2(WBUF_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int RR_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    // Registered FIFO bookkeeping and arbitration state
    logic [CNT_W-1:0]   count_q  [N_CORES];
    logic [CNT_W-1:0]   count_d  [N_CORES];
    logic [PTR_W-1:0]   wr_ptr_q [N_CORES];
    logic [PTR_W-1:0]   wr_ptr_d [N_CORES];
    logic [PTR_W-1:0]   rd_ptr_q [N_CORES];
    logic [PTR_W-1:0]   rd_ptr_d [N_CORES];
    logic [RR_W-1:0]    rr_ptr_q;
    logic [RR_W-1:0]    rr_ptr_d;
    logic [N_CORES-1:0] overflow_q;
    logic [N_CORES-1:0] overflow_d;

    // Storage arrays: written through enables, never reset
    logic [ADDR_W-1:0]  fifo_addr_q [N_CORES][WBUF_DEPTH];
    logic [DATA_W-1:0]  fifo_data_q [N_CORES][WBUF_DEPTH];
    logic [DATA_W-1:0]  mem_q       [MEM_DEPTH];

    logic [ADDR_W-1:0]  core_addr_lo [N_CORES];
    logic [DATA_W-1:0]  core_wdata_w [N_CORES];
    logic [N_CORES-1:0] full;
    logic [N_CORES-1:0] empty;
    logic [N_CORES-1:0] push;
    logic [N_CORES-1:0] pop;
    logic               grant_valid;
    logic [RR_W-1:0]    grant;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [N_CORES*DATA_W-1:0] rdata_all;
    logic               unused_addr_hi;

    // Split the flat core buses; upper address bits alias and are dropped
    always_comb begin
        unused_addr_hi = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            core_addr_lo[i] = bus.core_addr[16*i +: ADDR_W];
            core_wdata_w[i] = bus.core_wdata[DATA_W*i +: DATA_W];
            unused_addr_hi  = unused_addr_hi ^ (^bus.core_addr[16*i+ADDR_W +: 16-ADDR_W]);
        end
    end

    // Fullness and emptiness come straight from the registered counts
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < N_CORES; i++) begin
            full[i]  = (count_q[i] == CNT_W'(WBUF_DEPTH));
            empty[i] = (count_q[i] == '0);
        end
    end

    assign bus.wbuf_full  = full;
    assign bus.overflow   = overflow_q;
    assign bus.idle       = &empty;
    assign bus.core_rdata = rdata_all;

    // Round-robin pick: first non-empty FIFO at or after rr_ptr, wrapping
    always_comb begin : grant_scan
        int idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_CORES;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant       = RR_W'(idx);
            end
        end
    end

    // One memory write per cycle: host preload wins, else the granted FIFO head.
    // Drains are held off during reset so pending entries are discarded, not written.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        pop       = '0;
        rr_ptr_d  = rr_ptr_q;
        if (bus.host_wen) begin
            mem_we    = 1'b1;
            mem_waddr = bus.host_addr;
            mem_wdata = bus.host_wdata;
        end else if (grant_valid && !rst) begin
            pop[grant] = 1'b1;
            mem_we     = 1'b1;
            mem_waddr  = fifo_addr_q[grant][rd_ptr_q[grant]];
            mem_wdata  = fifo_data_q[grant][rd_ptr_q[grant]];
            if (int'(grant) == N_CORES - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant + RR_W'(1);
            end
        end
    end

    // Push accepts when not full (judged before this edge's pop); drops stick in overflow
    always_comb begin
        push       = '0;
        overflow_d = overflow_q;
        for (int i = 0; i < N_CORES; i++) begin
            push[i]       = bus.core_wen[i] && !full[i];
            overflow_d[i] = overflow_q[i] | (bus.core_wen[i] & full[i]);
            wr_ptr_d[i]   = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i]   = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]    = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // Read port: memory value, overridden by the youngest matching entry in the core's own FIFO
    always_comb begin : read_mux
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] rd;
        logic [PTR_W-1:0]  slot;
        rdata_all = '0;
        a         = '0;
        rd        = '0;
        slot      = '0;
        for (int i = 0; i < N_CORES; i++) begin
            a  = core_addr_lo[i];
            rd = mem_q[a];
            for (int k = 0; k < WBUF_DEPTH; k++) begin
                slot = rd_ptr_q[i] + PTR_W'(k);
                if ((CNT_W'(k) < count_q[i]) && (fifo_addr_q[i][slot] == a)) begin
                    rd = fifo_data_q[i][slot];
                end
            end
            rdata_all[DATA_W*i +: DATA_W] = rd;
        end
    end

    // Control state update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CORES; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            rr_ptr_q   <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                count_q[i]  <= count_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO slot and memory writes; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (push[i]) begin
                fifo_addr_q[i][wr_ptr_q[i]] <= core_addr_lo[i];
                fifo_data_q[i][wr_ptr_q[i]] <= core_wdata_w[i];
            end
        end
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_dm_write_arbiter.sv
// tb/tb_dm_write_arbiter.sv - directed vector bench for dm_write_arbiter
module tb_dm_write_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    dm_write_arbiter_if #(.N_CORES(4), .ADDR_W(8), .DATA_W(16)) bus ();

    dm_write_arbiter #(.N_CORES(4), .ADDR_W(8), .DATA_W(16), .WBUF_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hw;
        logic [7:0]  ha;
        logic [15:0] hd;
        logic [3:0]  wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  mask;
        logic [63:0] exp_rd;
        logic        chk;
        logic [3:0]  full;
        logic [3:0]  ovf;
        logic        idle;
    } vec_t;

    vec_t tv[$];

    function automatic logic [63:0] pk(int a0, int a1, int a2, int a3);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    function automatic vec_t mk(logic r, logic hw, int ha, int hd, logic [3:0] wen,
                                logic [63:0] a, logic [63:0] d, logic [3:0] mask,
                                logic [63:0] e, logic chk, logic [3:0] full,
                                logic [3:0] ovf, logic idle);
        vec_t v;
        v.rst = r; v.hw = hw; v.ha = ha[7:0]; v.hd = hd[15:0];
        v.wen = wen; v.addr = a; v.wdata = d; v.mask = mask; v.exp_rd = e;
        v.chk = chk; v.full = full; v.ovf = ovf; v.idle = idle;
        return v;
    endfunction

    task automatic set_in(input logic r, input logic hw, input logic [7:0] ha,
                          input logic [15:0] hd, input logic [3:0] wen,
                          input logic [63:0] a, input logic [63:0] d);
        rst            = r;
        bus.host_wen   = hw;
        bus.host_addr  = ha;
        bus.host_wdata = hd;
        bus.core_wen   = wen;
        bus.core_addr  = a;
        bus.core_wdata = d;
        #2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int c, input logic [15:0] exp);
        chk($sformatf("%s rdata[%0d]", tag, c), 64'(bus.core_rdata[16*c +: 16]), 64'(exp));
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] full,
                             input logic [3:0] ovf, input logic idle);
        chk({tag, " wbuf_full"}, 64'(bus.wbuf_full), 64'(full));
        chk({tag, " overflow"}, 64'(bus.overflow), 64'(ovf));
        chk({tag, " idle"}, 64'(bus.idle), 64'(idle));
    endtask

    initial begin
        clk = 1'b0;
        n_vec = 0;
        n_fail = 0;
        set_in(1'b1, 1'b0, 8'h0, 16'h0, 4'h0, 64'h0, 64'h0);
        repeat (2) @(negedge clk);

        // preload, forwarding, round-robin order, address collision
        tv.push_back(mk(0, 1, 5,  'h1234, 4'b0000, pk(0,0,0,0), 0, 4'b0000, 0, 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 3,  'h0303, 4'b0000, pk(5,5,0,0), 0, 4'b0011, pk('h1234,'h1234,0,0), 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 10, 'h0F0A, 4'b0000, pk(3,0,0,0), 0, 4'b0001, pk('h0303,0,0,0), 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 11, 'h0F0B, 4'b0000, pk(10,0,0,0), 0, 4'b0001, pk('h0F0A,0,0,0), 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 12, 'h0F0C, 4'b0000, pk(0,0,0,0), 0, 4'b0000, 0, 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 13, 'h0F0D, 4'b0000, pk(0,0,0,0), 0, 4'b0000, 0, 1, 0, 0, 1));
        tv.push_back(mk(0, 1, 7,  'h0F07, 4'b0000, pk(0,0,0,0), 0, 4'b0000, 0, 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'b0001, pk(3,3,0,0), pk('h00AA,0,0,0), 4'b0011, pk('h0303,'h0303,0,0), 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(3,3,0,0), 0, 4'b0011, pk('h00AA,'h0303,0,0), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(3,3,0,0), 0, 4'b0011, pk('h00AA,'h00AA,0,0), 1, 0, 0, 1));
        tv.push_back(mk(1, 0, 0, 0, 4'b0000, pk(0,0,0,0), 0, 4'b0000, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b1111, pk(10,11,12,13), pk('hA0,'hA1,'hA2,'hA3), 4'b1111, pk('h0F0A,'h0F0B,'h0F0C,'h0F0D), 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(10,11,12,13), 0, 4'b1111, pk('hA0,'hA1,'hA2,'hA3), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(12,11,10,11), 0, 4'b1111, pk('h0F0C,'hA1,'hA0,'h0F0B), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(11,13,12,12), 0, 4'b1111, pk('hA1,'h0F0D,'hA2,'h0F0C), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(12,13,10,13), 0, 4'b1111, pk('hA2,'h0F0D,'hA0,'hA3), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0010, pk(13,20,13,13), pk(0,'hB1,0,0), 4'b1101, pk('hA3,0,'hA3,'hA3), 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(13,20,20,13), 0, 4'b0010, pk(0,'hB1,0,0), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(20,20,20,20), 0, 4'b1111, pk('hB1,'hB1,'hB1,'hB1), 1, 0, 0, 1));
        tv.push_back(mk(1, 0, 0, 0, 4'b0000, pk(0,0,0,0), 0, 4'b0000, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0011, pk(7,7,7,7), pk('h1111,'h2222,0,0), 4'b1111, pk('h0F07,'h0F07,'h0F07,'h0F07), 1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(7,7,7,7), 0, 4'b1111, pk('h1111,'h2222,'h0F07,'h0F07), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(7,7,7,7), 0, 4'b1111, pk('h1111,'h2222,'h1111,'h1111), 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 4'b0000, pk(7,7,7,7), 0, 4'b1111, pk('h2222,'h2222,'h2222,'h2222), 1, 0, 0, 1));

        foreach (tv[r]) begin
            set_in(tv[r].rst, tv[r].hw, tv[r].ha, tv[r].hd, tv[r].wen, tv[r].addr, tv[r].wdata);
            for (int c = 0; c < 4; c++) begin
                if (tv[r].mask[c]) chk_rd($sformatf("v%0d", r), c, tv[r].exp_rd[16*c +: 16]);
            end
            if (tv[r].chk) chk_flags($sformatf("v%0d", r), tv[r].full, tv[r].ovf, tv[r].idle);
            @(negedge clk);
        end

        // overflow: host holds the port while core2 pushes 1..5
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, 1'b1, 8'(30 + c), 16'('hC000 + 30 + c), (c < 5) ? 4'b0100 : 4'b0000,
                   pk(0, (c == 5) ? 30 : 0, (c == 5) ? 34 : 30 + c, 0), pk(0, 0, c + 1, 0));
            if (c == 5) begin
                chk_rd("ovf hold", 2, 16'hC022);
                chk_rd("ovf hold", 1, 16'hC01E);
            end
            chk_flags($sformatf("ovf h%0d", c), (c >= 4) ? 4'b0100 : 4'b0000,
                      (c == 5) ? 4'b0100 : 4'b0000, c == 0);
            @(negedge clk);
        end
        // full before the pop: this push is dropped even though a pop happens
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0100, pk(0, 0, 35, 0), pk(0, 0, 6, 0));
        chk_flags("ovf h6", 4'b0100, 4'b0100, 1'b0);
        @(negedge clk);
        // push and pop together on core2
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0100, pk(31, 30, 36, 0), pk(0, 0, 7, 0));
        chk_rd("ovf d1", 1, 16'h0001);
        chk_rd("ovf d1", 0, 16'hC01F);
        chk_flags("ovf d1", 4'b0000, 4'b0100, 1'b0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0000, pk(32, 31, 35, 0), 64'h0);
        chk_rd("ovf d2", 2, 16'hC023);
        chk_rd("ovf d2", 1, 16'h0002);
        chk_rd("ovf d2", 0, 16'hC020);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0000, pk(33, 32, 36, 0), 64'h0);
        chk_rd("ovf d3", 2, 16'h0007);
        chk_rd("ovf d3", 1, 16'h0003);
        chk_rd("ovf d3", 0, 16'hC021);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0000, pk(0, 33, 0, 0), 64'h0);
        chk_rd("ovf d4", 1, 16'h0004);
        chk_flags("ovf d4", 4'b0000, 4'b0100, 1'b0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0000, pk(0, 36, 0, 0), 64'h0);
        chk_rd("ovf d5", 1, 16'h0007);
        chk_flags("ovf d5", 4'b0000, 4'b0100, 1'b1);
        @(negedge clk);

        // reset with three entries pending
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, 1'b1, 8'(50 + c), 16'('h5050 + 'h0101 * c), 4'b0000, 64'h0, 64'h0);
            @(negedge clk);
        end
        set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0111, pk(50, 51, 52, 0), pk('hE0, 'hE1, 'hE2, 0));
        chk_flags("rst p0", 4'b0000, 4'b0100, 1'b1);
        @(negedge clk);
        set_in(1'b1, 1'b0, 8'h0, 16'h0, 4'b0000, pk(50, 51, 52, 0), 64'h0);
        chk_rd("rst p1", 0, 16'h00E0);
        chk_flags("rst p1", 4'b0000, 4'b0100, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            set_in(1'b0, 1'b0, 8'h0, 16'h0, 4'b0000, pk(50, 51, 52, 0), 64'h0);
            chk_rd($sformatf("rst p%0d", c + 2), 0, 16'h5050);
            chk_rd($sformatf("rst p%0d", c + 2), 1, 16'h5151);
            chk_rd($sformatf("rst p%0d", c + 2), 2, 16'h5252);
            chk_flags($sformatf("rst p%0d", c + 2), 4'b0000, 4'b0000, 1'b1);
            chk($sformatf("rst p%0d rr_ptr", c + 2), 64'(dut.rr_ptr_q), 64'h0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
